stream_xbar_rr: RTL and testbench

STREAM_XBAR_RR -- requirements
Module: stream_xbar_rr

---
 rtl/stream_xbar_pkg.sv | 32 +++
 rtl/stream_xbar_port.sv | 149 ++++++++++++++
 rtl/stream_xbar_rr.sv | 115 +++++++++++
 tb/tb_stream_xbar_rr.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/stream_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_xbar_pkg
// Purpose : Shared types and helpers for the round-robin stream crossbar.
//           Holds the per-master arbiter state encoding and the width helper
//           used to size destination and source-id fields.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package stream_xbar_pkg;

  // Per-master-port arbiter state.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // ceil(log2(n)), but never narrower than one bit so that a single-port
  // configuration still has a legal index field.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) begin
        w = k + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_xbar_port.sv
`default_nettype none
// ============================================================================
// Module  : stream_xbar_port
// Purpose : One master port of the crossbar: a round-robin arbiter that locks
//           onto a slave for a whole packet, feeding a 2-entry output buffer.
// Ports   : clk, rst_n            - clock, synchronous active-low reset
//           i_req   [S]           - slaves asking to start a packet here
//           i_valid/i_data/i_last - full slave beat buses
//           o_ready [S]           - ready contribution towards each slave
//           o_lock  [S]           - one-hot of the slave owning this port
//           o_data/o_id/o_last/o_valid, i_ready - master stream side
// Revision: 1.0 - initial release
// ============================================================================
module stream_xbar_port
  import stream_xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int T_ID_WIDTH   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [S_DATA_COUNT-1:0]                i_req,
  input  logic [S_DATA_COUNT-1:0]                i_valid,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] i_data,
  input  logic [S_DATA_COUNT-1:0]                i_last,
  output logic [S_DATA_COUNT-1:0]                o_ready,
  output logic [S_DATA_COUNT-1:0]                o_lock,
  output logic [T_DATA_WIDTH-1:0]                o_data,
  output logic [T_ID_WIDTH-1:0]                  o_id,
  output logic                                   o_last,
  output logic                                   o_valid,
  input  logic                                   i_ready
);

  // Buffer entry layout: {data, id, last}
  localparam int C_BEAT_W = T_DATA_WIDTH + T_ID_WIDTH + 1;

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [T_ID_WIDTH-1:0]   r_rr_ptr;
  logic [T_ID_WIDTH-1:0]   w_rr_ptr_nxt;
  logic [T_ID_WIDTH-1:0]   r_gnt_id;
  logic [T_ID_WIDTH-1:0]   w_gnt_id_nxt;
  logic [T_ID_WIDTH-1:0]   w_sel;
  logic                    w_sel_vld;
  logic [T_ID_WIDTH-1:0]   w_idx;

  logic [C_BEAT_W-1:0]     r_head;
  logic                    r_head_vld;
  logic [C_BEAT_W-1:0]     r_tail;
  logic                    r_tail_vld;
  logic [C_BEAT_W-1:0]     w_push_beat;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;

  // Grant selection: a locked port keeps its owner; an idle port picks the
  // first requester at or after rr_ptr. Scanning from the far end lets the
  // nearest candidate overwrite the others.
  always_comb begin
    w_sel     = r_gnt_id;
    w_sel_vld = 1'b0;
    w_idx     = '0;
    if (r_state == ARB_LOCKED) begin
      w_sel_vld = 1'b1;
    end else begin
      for (int k = S_DATA_COUNT - 1; k >= 0; k--) begin
        w_idx = T_ID_WIDTH'((int'(r_rr_ptr) + k) % S_DATA_COUNT);
        if (i_req[w_idx]) begin
          w_sel     = w_idx;
          w_sel_vld = 1'b1;
        end
      end
    end
  end

  // Full depends only on registered occupancy, so ready never follows
  // the downstream ready combinationally.
  assign w_full      = r_tail_vld;
  assign o_ready     = (w_sel_vld && !w_full) ? (S_DATA_COUNT'(1) << w_sel) : '0;
  assign o_lock      = (r_state == ARB_LOCKED) ? (S_DATA_COUNT'(1) << r_gnt_id) : '0;
  assign w_push      = w_sel_vld && !w_full && i_valid[w_sel];
  assign w_pop       = r_head_vld && i_ready;
  assign w_push_beat = {i_data[w_sel], w_sel, i_last[w_sel]};

  // Arbiter next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_gnt_id_nxt = r_gnt_id;
    if (w_push) begin
      if (i_last[w_sel]) begin
        w_state_nxt  = ARB_IDLE;
        w_rr_ptr_nxt = T_ID_WIDTH'((int'(w_sel) + 1) % S_DATA_COUNT);
      end else begin
        w_state_nxt  = ARB_LOCKED;
        w_gnt_id_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_gnt_id <= w_gnt_id_nxt;
    end
  end

  // 2-entry buffer; the head register drives the master outputs directly.
  // A push while full cannot happen because ready is withheld.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_head_vld <= 1'b0;
      r_tail     <= '0;
      r_tail_vld <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_vld) begin
        r_head     <= r_tail;
        r_tail_vld <= 1'b0;
      end else if (w_push) begin
        r_head <= w_push_beat;
      end else begin
        r_head_vld <= 1'b0;
      end
    end else if (w_push) begin
      if (r_head_vld) begin
        r_tail     <= w_push_beat;
        r_tail_vld <= 1'b1;
      end else begin
        r_head     <= w_push_beat;
        r_head_vld <= 1'b1;
      end
    end
  end

  assign o_valid = r_head_vld;
  assign o_data  = r_head[C_BEAT_W-1:T_ID_WIDTH+1];
  assign o_id    = r_head[T_ID_WIDTH:1];
  assign o_last  = r_head[0];

endmodule
`default_nettype wire

// File: rtl/stream_xbar_rr.sv
`default_nettype none
// ============================================================================
// Module  : stream_xbar_rr
// Purpose : Packet stream crossbar, S slaves to M masters, with an independent
//           round-robin packet arbiter and 2-entry buffer per master port.
//           Packets aimed at a nonexistent master are accepted and dropped.
// Ports   : clk, rst_n                     - clock, sync active-low reset
//           s_data_i/s_dest_i/s_last_i/s_valid_i, s_ready_o - slave side
//           m_data_o/m_id_o/m_last_o/m_valid_o, m_ready_i   - master side
// Revision: 1.0 - initial release
// ============================================================================
module stream_xbar_rr
  import stream_xbar_pkg::*;
#(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int S_DATA_COUNT = 2,
  parameter  int M_DATA_COUNT = 3,
  localparam int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT),
  localparam int T_ID_WIDTH   = clog2_min1(S_DATA_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT-1:0][T_ID_WIDTH-1:0]   m_id_o,
  output logic [M_DATA_COUNT-1:0]                   m_last_o,
  output logic [M_DATA_COUNT-1:0]                   m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                   m_ready_i
);

  logic [S_DATA_COUNT-1:0] w_port_ready [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] w_port_lock  [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] w_req        [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] w_locked_any;
  logic [S_DATA_COUNT-1:0] w_dest_bad;
  logic [S_DATA_COUNT-1:0] w_busy;
  logic [S_DATA_COUNT-1:0] w_drop_ready;
  logic [S_DATA_COUNT-1:0] w_ready_any;
  logic [S_DATA_COUNT-1:0] r_drop;

  // A slave already owning a port, or inside a dropped packet, must not
  // start a packet anywhere else even if its dest changes mid-packet.
  always_comb begin
    w_locked_any = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      w_locked_any = w_locked_any | w_port_lock[m];
    end
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      w_dest_bad[i] = int'(s_dest_i[i]) >= M_DATA_COUNT;
    end
    w_busy       = w_locked_any | r_drop;
    w_drop_ready = r_drop | (w_dest_bad & ~w_locked_any);
  end

  always_comb begin
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      w_req[m] = '0;
      for (int i = 0; i < S_DATA_COUNT; i++) begin
        w_req[m][i] = s_valid_i[i] && !w_busy[i] &&
                      (s_dest_i[i] == T_DEST_WIDTH'(m));
      end
    end
  end

  always_comb begin
    w_ready_any = w_drop_ready;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      w_ready_any = w_ready_any | w_port_ready[m];
    end
  end

  assign s_ready_o = rst_n ? w_ready_any : '0;

  // Discard state: set on a non-last beat swallowed by the drop path,
  // cleared by the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else begin
      for (int i = 0; i < S_DATA_COUNT; i++) begin
        if (s_valid_i[i] && w_drop_ready[i]) begin
          r_drop[i] <= !s_last_i[i];
        end
      end
    end
  end

  for (genvar gm = 0; gm < M_DATA_COUNT; gm++) begin : g_port
    stream_xbar_port #(
      .T_DATA_WIDTH (T_DATA_WIDTH),
      .S_DATA_COUNT (S_DATA_COUNT),
      .T_ID_WIDTH   (T_ID_WIDTH)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (w_req[gm]),
      .i_valid (s_valid_i),
      .i_data  (s_data_i),
      .i_last  (s_last_i),
      .o_ready (w_port_ready[gm]),
      .o_lock  (w_port_lock[gm]),
      .o_data  (m_data_o[gm]),
      .o_id    (m_id_o[gm]),
      .o_last  (m_last_o[gm]),
      .o_valid (m_valid_o[gm]),
      .i_ready (m_ready_i[gm])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_xbar_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_xbar_rr
// Purpose : Directed vector bench for stream_xbar_rr (W=4, S=2, M=3).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_xbar_rr;

  logic            clk;
  logic            rst_n;
  logic [1:0][3:0] s_data_i;
  logic [1:0][1:0] s_dest_i;
  logic [1:0]      s_last_i;
  logic [1:0]      s_valid_i;
  logic [1:0]      s_ready_o;
  logic [2:0][3:0] m_data_o;
  logic [2:0]      m_id_o;
  logic [2:0]      m_last_o;
  logic [2:0]      m_valid_o;
  logic [2:0]      m_ready_i;

  int checks;
  int errors;

  stream_xbar_rr #(
    .T_DATA_WIDTH (4),
    .S_DATA_COUNT (2),
    .M_DATA_COUNT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_dest_i  (s_dest_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_id_o    (m_id_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock cycle: inputs for the cycle, the s_ready expected
  // during it, and the master outputs expected from earlier edges.
  // chk: 0 = s_ready only, 1 = plus valid ports, 2 = plus all ports (zeros).
  typedef struct {
    bit        rst;
    bit [1:0]  vld;
    bit [1:0]  d1;
    bit [1:0]  d0;
    bit [1:0]  lst;
    bit [3:0]  x1;
    bit [3:0]  x0;
    bit [2:0]  mr;
    bit [1:0]  esr;
    bit [2:0]  emv;
    bit [11:0] ed;
    bit [2:0]  eid;
    bit [2:0]  el;
    int        chk;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rst, bit [1:0] vld, bit [1:0] d1, bit [1:0] d0,
                              bit [1:0] lst, bit [3:0] x1, bit [3:0] x0, bit [2:0] mr,
                              bit [1:0] esr, bit [2:0] emv, bit [11:0] ed,
                              bit [2:0] eid, bit [2:0] el, int chk);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d1 = d1; v.d0 = d0; v.lst = lst;
    v.x1 = x1; v.x0 = x0; v.mr = mr; v.esr = esr; v.emv = emv;
    v.ed = ed; v.eid = eid; v.el = el; v.chk = chk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    s_data_i  = '0;
    s_dest_i  = '0;
    s_last_i  = '0;
    s_valid_i = '0;
    m_ready_i = 3'b111;

    //              rst vld    d1   d0   lst    x1    x0    mr      esr    emv     ed       eid     el    chk
    // reset with both slaves valid
    vq.push_back(mk(0, 2'b11, 2'd0, 2'd1, 2'b11, 4'h5, 4'hA, 3'b111, 2'b00, 3'b000, 12'h000, 3'b000, 3'b000, 0));
    vq.push_back(mk(0, 2'b11, 2'd0, 2'd1, 2'b11, 4'h5, 4'hA, 3'b111, 2'b00, 3'b000, 12'h000, 3'b000, 3'b000, 2));
    // parallel routing to different masters
    vq.push_back(mk(1, 2'b11, 2'd0, 2'd1, 2'b11, 4'h5, 4'hA, 3'b111, 2'b11, 3'b000, 12'h000, 3'b000, 3'b000, 2));
    vq.push_back(mk(1, 2'b00, 2'd0, 2'd1, 2'b11, 4'h5, 4'hA, 3'b111, 2'b00, 3'b011, 12'h0A5, 3'b001, 3'b011, 1));
    // contention on port 0; s0 dest flips to 1 mid-packet and is ignored
    vq.push_back(mk(1, 2'b11, 2'd0, 2'd0, 2'b00, 4'h7, 4'h1, 3'b111, 2'b01, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b11, 2'd0, 2'd1, 2'b00, 4'h7, 4'h2, 3'b111, 2'b01, 3'b001, 12'h001, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b11, 2'd0, 2'd0, 2'b01, 4'h7, 4'h3, 3'b111, 2'b01, 3'b001, 12'h002, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b10, 2'd0, 2'd0, 2'b00, 4'h7, 4'h3, 3'b111, 2'b10, 3'b001, 12'h003, 3'b000, 3'b001, 1));
    vq.push_back(mk(1, 2'b10, 2'd0, 2'd0, 2'b00, 4'h8, 4'h0, 3'b111, 2'b10, 3'b001, 12'h007, 3'b001, 3'b000, 1));
    vq.push_back(mk(1, 2'b10, 2'd0, 2'd0, 2'b10, 4'h9, 4'h0, 3'b111, 2'b10, 3'b001, 12'h008, 3'b001, 3'b000, 1));
    vq.push_back(mk(1, 2'b00, 2'd0, 2'd0, 2'b00, 4'h0, 4'h0, 3'b111, 2'b00, 3'b001, 12'h009, 3'b001, 3'b001, 1));
    // fairness on port 2 with single-beat packets
    vq.push_back(mk(1, 2'b11, 2'd2, 2'd2, 2'b11, 4'hE, 4'h3, 3'b111, 2'b01, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b11, 2'd2, 2'd2, 2'b11, 4'hE, 4'h3, 3'b111, 2'b10, 3'b100, 12'h300, 3'b000, 3'b100, 1));
    vq.push_back(mk(1, 2'b11, 2'd2, 2'd2, 2'b11, 4'hE, 4'h3, 3'b111, 2'b01, 3'b100, 12'hE00, 3'b100, 3'b100, 1));
    vq.push_back(mk(1, 2'b11, 2'd2, 2'd2, 2'b11, 4'hE, 4'h3, 3'b111, 2'b10, 3'b100, 12'h300, 3'b000, 3'b100, 1));
    vq.push_back(mk(1, 2'b00, 2'd2, 2'd2, 2'b11, 4'hE, 4'h3, 3'b111, 2'b00, 3'b100, 12'hE00, 3'b100, 3'b100, 1));
    // backpressure on port 0
    vq.push_back(mk(1, 2'b01, 2'd0, 2'd0, 2'b01, 4'h0, 4'h4, 3'b110, 2'b01, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b01, 2'd0, 2'd0, 2'b01, 4'h0, 4'h5, 3'b110, 2'b01, 3'b001, 12'h004, 3'b000, 3'b001, 1));
    vq.push_back(mk(1, 2'b01, 2'd0, 2'd0, 2'b01, 4'h0, 4'h6, 3'b110, 2'b00, 3'b001, 12'h004, 3'b000, 3'b001, 1));
    vq.push_back(mk(1, 2'b01, 2'd0, 2'd0, 2'b01, 4'h0, 4'h6, 3'b111, 2'b00, 3'b001, 12'h004, 3'b000, 3'b001, 1));
    vq.push_back(mk(1, 2'b01, 2'd0, 2'd0, 2'b01, 4'h0, 4'h6, 3'b111, 2'b01, 3'b001, 12'h005, 3'b000, 3'b001, 1));
    vq.push_back(mk(1, 2'b00, 2'd0, 2'd0, 2'b01, 4'h0, 4'h6, 3'b111, 2'b00, 3'b001, 12'h006, 3'b000, 3'b001, 1));
    // invalid destination is swallowed
    vq.push_back(mk(1, 2'b10, 2'd3, 2'd0, 2'b00, 4'h9, 4'h0, 3'b111, 2'b10, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b10, 2'd3, 2'd0, 2'b10, 4'hA, 4'h0, 3'b111, 2'b10, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b00, 2'd0, 2'd0, 2'b00, 4'h0, 4'h0, 3'b111, 2'b00, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    // reset in the middle of a packet on port 1
    vq.push_back(mk(1, 2'b01, 2'd0, 2'd1, 2'b00, 4'h0, 4'h7, 3'b111, 2'b01, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(0, 2'b01, 2'd0, 2'd1, 2'b00, 4'h0, 4'h8, 3'b111, 2'b00, 3'b010, 12'h070, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b00, 2'd0, 2'd1, 2'b00, 4'h0, 4'h0, 3'b111, 2'b00, 3'b000, 12'h000, 3'b000, 3'b000, 2));
    vq.push_back(mk(1, 2'b10, 2'd1, 2'd0, 2'b10, 4'h2, 4'h0, 3'b111, 2'b10, 3'b000, 12'h000, 3'b000, 3'b000, 1));
    vq.push_back(mk(1, 2'b00, 2'd1, 2'd0, 2'b00, 4'h0, 4'h0, 3'b111, 2'b00, 3'b010, 12'h020, 3'b010, 3'b010, 1));

    for (int n = 0; n < vq.size(); n++) begin
      vec_t v;
      v = vq[n];
      @(negedge clk);
      rst_n     = v.rst;
      s_valid_i = v.vld;
      s_dest_i  = {v.d1, v.d0};
      s_last_i  = v.lst;
      s_data_i  = {v.x1, v.x0};
      m_ready_i = v.mr;
      #1;
      check($sformatf("v%0d s_ready", n), 32'(s_ready_o), 32'(v.esr));
      if (v.chk != 0) begin
        check($sformatf("v%0d m_valid", n), 32'(m_valid_o), 32'(v.emv));
        for (int p = 0; p < 3; p++) begin
          if (v.chk == 2 || v.emv[p]) begin
            check($sformatf("v%0d port%0d beat", n, p),
                  32'({m_data_o[p], m_id_o[p], m_last_o[p]}),
                  32'({v.ed[p*4 +: 4], v.eid[p], v.el[p]}));
          end
        end
      end
    end

    // Sustained 8-beat packet s0 -> port 1: one beat per cycle, no stall.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst_n     = 1'b1;
      s_valid_i = 2'b01;
      s_dest_i  = {2'd0, 2'd1};
      s_last_i  = {1'b0, (k == 7)};
      s_data_i  = {4'h0, 4'(k + 3)};
      m_ready_i = 3'b111;
      #1;
      check($sformatf("burst%0d s_ready", k), 32'(s_ready_o), 32'h1);
      if (k > 0) begin
        check($sformatf("burst%0d port1", k),
              32'({m_valid_o[1], m_data_o[1], m_id_o[1], m_last_o[1]}),
              32'({1'b1, 4'(k + 2), 1'b0, 1'b0}));
      end
    end
    @(negedge clk);
    s_valid_i = 2'b00;
    #1;
    check("burst tail port1",
          32'({m_valid_o, m_data_o[1], m_id_o[1], m_last_o[1]}),
          32'({3'b010, 4'hA, 1'b0, 1'b1}));
    @(negedge clk);
    #1;
    check("burst drained", 32'(m_valid_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
